// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM for the multicycle RV32I core.
// Drives the PC / ALU / writeback mux selects and the datapath enables.
// Waits on instruction- and data-memory ready handshakes and traps on a
// bus timeout or an illegal opcode.
// Optional feature: define INSTRET_COUNTER_EN to build the 32-bit
// retired-instruction counter. Without it, instret is tied to zero.
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        dmem_wren,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  writeback_src,
    output logic [1:0]  pc_src,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state_dbg,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_ALU = 4'd6,
        S_WB_MEM = 4'd7,
        S_WB_IMM = 4'd8,
        S_JUMP   = 4'd9,
        S_JALR   = 4'd10,
        S_BRANCH = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [15:0] wait_q, wait_d;

    // funct3/funct7 go straight from the decoder to the ALU control in the
    // datapath; the sequencer itself only needs the opcode.
    logic unused_decoder_fields;
    assign unused_decoder_fields = ^{funct3, funct7};

    // State, trap cause and memory wait counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cause_q <= 2'b00;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state, wait-counter update and output decode; strobes are gated off while reset is high
    always_comb begin
        state_d       = state_q;
        cause_d       = cause_q;
        wait_d        = 16'd0;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        dmem_wren     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        writeback_src = 2'b00;
        pc_src        = 2'b00;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_a = 2'b00;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b00;
                    pc_src    = 2'b00;
                    state_d   = S_DECODE;
                end else if (wait_q == TIMEOUT_LIMIT) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                alu_op    = 2'b00;
                case (opcode)
                    OP_R, OP_I:           state_d = S_EXEC;
                    OP_LOAD, OP_STORE:    state_d = S_ADDR;
                    OP_LUI:               state_d = S_WB_IMM;
                    OP_AUIPC:             state_d = S_WB_ALU;
                    OP_JAL:               state_d = S_JUMP;
                    OP_JALR:              state_d = S_JALR;
                    OP_BRANCH:            state_d = S_BRANCH;
                    OP_FENCE, OP_SYSTEM:  state_d = S_FETCH;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a = 2'b01;
                if (opcode == OP_R) begin
                    alu_src_b = 2'b00;
                    alu_op    = 2'b01;
                end else begin
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                end
                state_d = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b00;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                dmem_req  = 1'b1;
                dmem_wren = (state_q == S_MEM_WR);
                if (dmem_ready) begin
                    state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (wait_q == TIMEOUT_LIMIT) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WB_ALU: begin
                reg_write     = 1'b1;
                writeback_src = 2'b00;
                state_d       = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write     = 1'b1;
                writeback_src = 2'b01;
                state_d       = S_FETCH;
            end
            S_WB_IMM: begin
                reg_write     = 1'b1;
                writeback_src = 2'b10;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                reg_write     = 1'b1;
                writeback_src = 2'b11;
                pc_write      = 1'b1;
                pc_src        = 2'b01;
                state_d       = S_FETCH;
            end
            S_JALR: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b10;
                alu_op        = 2'b00;
                pc_src        = 2'b10;
                pc_write      = 1'b1;
                reg_write     = 1'b1;
                writeback_src = 2'b11;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b00;
                alu_op    = 2'b11;
                pc_write  = branch_taken;
                pc_src    = 2'b01;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (reset) begin
            imem_req      = 1'b0;
            dmem_req      = 1'b0;
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            dmem_wren     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            writeback_src = 2'b00;
            pc_src        = 2'b00;
        end
    end

    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state_dbg  = state_q;

`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret_q, instret_d;

    // Count one retirement each time a non-fetch, non-trap state hands back to FETCH
    always_comb begin
        instret_d = instret_q;
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP) begin
            instret_d = instret_q + 32'd1;
        end
    end

    // Retired-instruction counter register, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed self-checking bench for multicycle_sequencer.
// The DUT is built with MEM_TIMEOUT=4 so the bus-timeout path is reachable quickly.
// Inputs are driven at the falling edge and outputs sampled 1 ns later, or 1 ns after a rising edge.
module tb_multicycle_sequencer;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

`ifdef INSTRET_COUNTER_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, dmem_req, pc_write, ir_write, reg_write, dmem_wren;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, writeback_src, pc_src;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [3:0]  state_dbg;
    logic [31:0] instret;
    logic        any_strobe;

    int          total;
    int          bad;
    logic [31:0] exp_instret;

    assign any_strobe = imem_req | dmem_req | pc_write | ir_write | reg_write | dmem_wren;

    multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .branch_taken  (branch_taken),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .dmem_wren     (dmem_wren),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .writeback_src (writeback_src),
        .pc_src        (pc_src),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .state_dbg     (state_dbg),
        .instret       (instret)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        total++; if (any_strobe !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes_first: got %0b expected 0", any_strobe); end
        @(negedge clk);
        #1;
        total++; if (state_dbg !== 4'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state_dbg); end
        total++; if (trap !== 1'b0) begin bad++; $display("[TB] FAIL reset_trap: got %0b expected 0", trap); end
        total++; if (trap_cause !== 2'b00) begin bad++; $display("[TB] FAIL reset_cause: got %0b expected 00", trap_cause); end
        total++; if (instret !== 32'd0) begin bad++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret); end
        total++; if (any_strobe !== 1'b0) begin bad++; $display("[TB] FAIL reset_strobes: got %0b expected 0", any_strobe); end
        exp_instret = 32'd0;
    endtask

    task automatic test_alu();
        logic [6:0] ops [2];
        logic [3:0] exp_st [4];
        int writes;
        ops[0] = OP_R; ops[1] = OP_I;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd6};
        for (int k = 0; k < 2; k++) begin
            writes = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                reset = 1'b0; opcode = ops[k]; imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b0;
                #1;
                total++; if (state_dbg !== exp_st[i]) begin bad++; $display("[TB] FAIL alu_state k=%0d i=%0d: got %0d expected %0d", k, i, state_dbg, exp_st[i]); end
                if (reg_write === 1'b1) writes++;
                if (i == 0) begin
                    total++; if ({ir_write, pc_write, alu_src_b} !== 4'b1101) begin bad++; $display("[TB] FAIL fetch_ctrl: got %b expected 1101", {ir_write, pc_write, alu_src_b}); end
                end
                if (i == 2) begin
                    total++; if ({alu_src_a, alu_src_b, alu_op} !== (k == 0 ? 6'b010001 : 6'b011010)) begin bad++; $display("[TB] FAIL exec_ctrl k=%0d: got %b", k, {alu_src_a, alu_src_b, alu_op}); end
                end
                if (i == 3) begin
                    total++; if ({reg_write, writeback_src} !== 3'b100) begin bad++; $display("[TB] FAIL wb_alu k=%0d: got %b expected 100", k, {reg_write, writeback_src}); end
                end
            end
            total++; if (writes !== 1) begin bad++; $display("[TB] FAIL alu_write_count k=%0d: got %0d expected 1", k, writes); end
            @(posedge clk); #1;
            exp_instret = exp_instret + 32'(CNT_EN);
            total++; if (state_dbg !== 4'd0) begin bad++; $display("[TB] FAIL alu_return k=%0d: got %0d expected 0", k, state_dbg); end
            total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL alu_instret k=%0d: got %0d expected %0d", k, instret, exp_instret); end
        end
    endtask

    task automatic test_load_wait();
        logic [3:0] exp_st [8];
        int writes;
        exp_st = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd7};
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reset = 1'b0; opcode = OP_LOAD; imem_ready = 1'b1;
            dmem_ready = (i < 3) || (i == 6);
            #1;
            total++; if (state_dbg !== exp_st[i]) begin bad++; $display("[TB] FAIL load_state i=%0d: got %0d expected %0d", i, state_dbg, exp_st[i]); end
            if (reg_write === 1'b1) writes++;
            if (i >= 3 && i <= 6) begin
                total++; if ({dmem_req, dmem_wren} !== 2'b10) begin bad++; $display("[TB] FAIL load_req i=%0d: got %b expected 10", i, {dmem_req, dmem_wren}); end
            end
            if (i == 7) begin
                total++; if ({reg_write, writeback_src} !== 3'b101) begin bad++; $display("[TB] FAIL load_wb: got %b expected 101", {reg_write, writeback_src}); end
            end
        end
        total++; if (writes !== 1) begin bad++; $display("[TB] FAIL load_write_count: got %0d expected 1", writes); end
        @(posedge clk); #1;
        exp_instret = exp_instret + 32'(CNT_EN);
        total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL load_instret: got %0d expected %0d", instret, exp_instret); end
    endtask

    task automatic test_store();
        logic [3:0] exp_st [4];
        exp_st = '{4'd0, 4'd1, 4'd3, 4'd5};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset = 1'b0; opcode = OP_STORE; imem_ready = 1'b1; dmem_ready = 1'b1;
            #1;
            total++; if (state_dbg !== exp_st[i]) begin bad++; $display("[TB] FAIL store_state i=%0d: got %0d expected %0d", i, state_dbg, exp_st[i]); end
            if (i == 3) begin
                total++; if ({dmem_req, dmem_wren, reg_write} !== 3'b110) begin bad++; $display("[TB] FAIL store_ctrl: got %b expected 110", {dmem_req, dmem_wren, reg_write}); end
            end
        end
        @(posedge clk); #1;
        exp_instret = exp_instret + 32'(CNT_EN);
        total++; if (state_dbg !== 4'd0) begin bad++; $display("[TB] FAIL store_return: got %0d expected 0", state_dbg); end
        total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL store_instret: got %0d expected %0d", instret, exp_instret); end
    endtask

    task automatic test_upper_imm();
        logic [6:0] ops [2];
        logic [3:0] last_st [2];
        logic [1:0] wb [2];
        ops[0] = OP_LUI; ops[1] = OP_AUIPC;
        last_st[0] = 4'd8; last_st[1] = 4'd6;
        wb[0] = 2'b10; wb[1] = 2'b00;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                reset = 1'b0; opcode = ops[k]; imem_ready = 1'b1;
                #1;
                if (i == 2) begin
                    total++; if (state_dbg !== last_st[k]) begin bad++; $display("[TB] FAIL upper_state k=%0d: got %0d expected %0d", k, state_dbg, last_st[k]); end
                    total++; if ({reg_write, writeback_src} !== {1'b1, wb[k]}) begin bad++; $display("[TB] FAIL upper_wb k=%0d: got %b expected %b", k, {reg_write, writeback_src}, {1'b1, wb[k]}); end
                end
            end
            @(posedge clk); #1;
            exp_instret = exp_instret + 32'(CNT_EN);
            total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL upper_instret k=%0d: got %0d expected %0d", k, instret, exp_instret); end
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                reset = 1'b0; opcode = OP_BRANCH; imem_ready = 1'b1; branch_taken = (k == 0);
                #1;
                if (i == 2) begin
                    total++; if (state_dbg !== 4'd11) begin bad++; $display("[TB] FAIL branch_state k=%0d: got %0d expected 11", k, state_dbg); end
                    total++; if ({pc_write, pc_src} !== {(k == 0), 2'b01}) begin bad++; $display("[TB] FAIL branch_pc k=%0d: got %b expected %b", k, {pc_write, pc_src}, {(k == 0), 2'b01}); end
                    total++; if ({alu_src_a, alu_src_b, alu_op, reg_write} !== 7'b0100110) begin bad++; $display("[TB] FAIL branch_alu k=%0d: got %b expected 0100110", k, {alu_src_a, alu_src_b, alu_op, reg_write}); end
                end
            end
            @(posedge clk); #1;
            exp_instret = exp_instret + 32'(CNT_EN);
            total++; if (state_dbg !== 4'd0) begin bad++; $display("[TB] FAIL branch_return k=%0d: got %0d expected 0", k, state_dbg); end
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_jumps();
        logic [6:0] ops [2];
        logic [3:0] last_st [2];
        logic [1:0] psrc [2];
        logic [1:0] srca [2];
        ops[0] = OP_JAL; ops[1] = OP_JALR;
        last_st[0] = 4'd9; last_st[1] = 4'd10;
        psrc[0] = 2'b01; psrc[1] = 2'b10;
        srca[0] = 2'b00; srca[1] = 2'b01;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                reset = 1'b0; opcode = ops[k]; imem_ready = 1'b1;
                #1;
                if (i == 2) begin
                    total++; if (state_dbg !== last_st[k]) begin bad++; $display("[TB] FAIL jump_state k=%0d: got %0d expected %0d", k, state_dbg, last_st[k]); end
                    total++; if ({pc_write, reg_write, writeback_src} !== 4'b1111) begin bad++; $display("[TB] FAIL jump_wr k=%0d: got %b expected 1111", k, {pc_write, reg_write, writeback_src}); end
                    total++; if ({pc_src, alu_src_a} !== {psrc[k], srca[k]}) begin bad++; $display("[TB] FAIL jump_src k=%0d: got %b expected %b", k, {pc_src, alu_src_a}, {psrc[k], srca[k]}); end
                end
            end
            @(posedge clk); #1;
            exp_instret = exp_instret + 32'(CNT_EN);
            total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL jump_instret k=%0d: got %0d expected %0d", k, instret, exp_instret); end
        end
    endtask

    task automatic test_fence_system();
        logic [6:0] ops [2];
        ops[0] = OP_FENCE; ops[1] = OP_SYSTEM;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                reset = 1'b0; opcode = ops[k]; imem_ready = 1'b1;
                #1;
                if (i == 1) begin
                    total++; if ({state_dbg, any_strobe} !== 5'b00010) begin bad++; $display("[TB] FAIL nop_decode k=%0d: got %b expected 00010", k, {state_dbg, any_strobe}); end
                end
            end
            @(posedge clk); #1;
            exp_instret = exp_instret + 32'(CNT_EN);
            total++; if (state_dbg !== 4'd0) begin bad++; $display("[TB] FAIL nop_return k=%0d: got %0d expected 0", k, state_dbg); end
            total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL nop_instret k=%0d: got %0d expected %0d", k, instret, exp_instret); end
        end
    endtask

    task automatic test_reset_midway();
        logic [3:0] exp_st [4];
        exp_st = '{4'd0, 4'd1, 4'd3, 4'd5};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset = (i == 3); opcode = OP_STORE; imem_ready = 1'b1; dmem_ready = 1'b1;
            #1;
            total++; if (state_dbg !== exp_st[i]) begin bad++; $display("[TB] FAIL midreset_state i=%0d: got %0d expected %0d", i, state_dbg, exp_st[i]); end
        end
        total++; if ({dmem_req, dmem_wren} !== 2'b00) begin bad++; $display("[TB] FAIL midreset_strobes: got %b expected 00", {dmem_req, dmem_wren}); end
        @(posedge clk); #1;
        exp_instret = 32'd0;
        total++; if (state_dbg !== 4'd0) begin bad++; $display("[TB] FAIL midreset_return: got %0d expected 0", state_dbg); end
        total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL midreset_instret: got %0d expected 0", instret); end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            reset = 1'b0; opcode = 7'b0000000; imem_ready = 1'b1; dmem_ready = 1'b0;
            #1;
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            imem_ready = 1'b1; dmem_ready = 1'b1; branch_taken = 1'b1; opcode = OP_R;
            #1;
            total++; if ({state_dbg, trap, trap_cause, any_strobe} !== 8'b1100_1_01_0) begin bad++; $display("[TB] FAIL illegal_trap j=%0d: got %b expected 11001010", j, {state_dbg, trap, trap_cause, any_strobe}); end
        end
        total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL illegal_instret: got %0d expected %0d", instret, exp_instret); end
        @(negedge clk);
        reset = 1'b1; branch_taken = 1'b0;
        @(posedge clk); #1;
        exp_instret = 32'd0;
        total++; if ({state_dbg, trap, trap_cause} !== 7'b0000_0_00) begin bad++; $display("[TB] FAIL illegal_reset: got %b expected 0000000", {state_dbg, trap, trap_cause}); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset = 1'b0; opcode = OP_R; imem_ready = 1'b0; dmem_ready = 1'b0;
            #1;
            total++; if ({state_dbg, trap, imem_req} !== 6'b0000_0_1) begin bad++; $display("[TB] FAIL timeout_wait i=%0d: got %b expected 000001", i, {state_dbg, trap, imem_req}); end
        end
        @(posedge clk); #1;
        total++; if ({state_dbg, trap, trap_cause} !== 7'b1100_1_10) begin bad++; $display("[TB] FAIL timeout_trap: got %b expected 1100110", {state_dbg, trap, trap_cause}); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if ({state_dbg, trap, trap_cause} !== 7'b0000_0_00) begin bad++; $display("[TB] FAIL timeout_reset: got %b expected 0000000", {state_dbg, trap, trap_cause}); end
    endtask

    task automatic test_ready_wins();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            reset = 1'b0; opcode = OP_FENCE; imem_ready = (i == 4);
            #1;
        end
        @(posedge clk); #1;
        total++; if ({state_dbg, trap} !== 5'b0001_0) begin bad++; $display("[TB] FAIL ready_wins: got %b expected 00010", {state_dbg, trap}); end
        @(negedge clk);
        imem_ready = 1'b1;
        @(posedge clk); #1;
        exp_instret = exp_instret + 32'(CNT_EN);
        total++; if (state_dbg !== 4'd0) begin bad++; $display("[TB] FAIL ready_wins_return: got %0d expected 0", state_dbg); end
        total++; if (instret !== exp_instret) begin bad++; $display("[TB] FAIL ready_wins_instret: got %0d expected %0d", instret, exp_instret); end
    endtask

    // Run every scenario in order and report
    initial begin
        total = 0; bad = 0; exp_instret = 32'd0;
        reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_upper_imm();
        test_branch();
        test_jumps();
        test_fence_system();
        test_reset_midway();
        test_illegal();
        test_timeout();
        test_ready_wins();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Parametrised control sequencer for the multicycle RV32I core, the successor to the fixed single-clock control unit. It sits between the instruction decoder and the datapath muxes (PC, ALU A/B, writeback). Beyond the original it handles instruction- and data-memory ready handshakes with wait states, a bus timeout, branch/JAL/JALR/AUIPC sequencing, and a sticky trap for illegal opcodes.

## Interface
- MEM_TIMEOUT, 255: maximum wait cycles on a memory request before a bus-error trap; legal range 1–65535.
- clk  input  1  system clock; the block uses one clock.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  from instruction decoder (IR[6:0]).
- funct3  input  3  from instruction decoder.
- funct7  input  7  from instruction decoder.
- branch_taken  input  1  combinational compare result of reg_a vs reg_b per funct3.
- imem_ready  input  1  instruction memory data valid this cycle.
- dmem_ready  input  1  data memory read data valid / write accepted this cycle.
- imem_req, dmem_req  output  1  memory request strobes.
- pc_write, ir_write, reg_write, dmem_wren  output  1  datapath enables.
- alu_src_a  output  2  00 pc, 01 reg_a, 10 old_pc.
- alu_src_b  output  2  00 reg_b, 01 const 4, 10 reg_imm.
- alu_op  output  2  00 force add, 01 R-type funct3/funct7, 10 I-type (funct7 used only for shifts), 11 compare.
- writeback_src  output  2  00 alu_out_reg, 01 mem_data_reg, 10 reg_imm, 11 pc.
- pc_src  output  2  00 alu_result, 01 alu_out_reg, 10 {alu_result[31:1],1'b0}.
- trap  output  1  sticky fault flag.
- trap_cause  output  2  00 none, 01 illegal opcode, 10 bus timeout.
- state_dbg  output  4  current state encoding.
- instret  output  32  retired-instruction count (see Configuration).

## Operation
- Outputs are decoded combinationally from state (plus ready/branch_taken); any output not listed for a state is 0.
- FETCH: imem_req=1; on imem_ready: ir_write=1, pc_write=1, a=pc, b=4, alu_op=00, pc_src=00, -> DECODE; else stay.
- DECODE: a=old_pc, b=imm, alu_op=00 (branch/JAL/AUIPC target into alu_out_reg). Next by opcode: 0110011/0010011 -> EXEC; 0000011/0100011 -> ADDR; 0110111 -> WB_IMM; 0010111 -> WB_ALU; 1101111 -> JUMP; 1100111 -> JALR; 1100011 -> BRANCH; 0001111/1110011 -> FETCH (no-op, retires); anything else -> TRAP, cause 01.
- EXEC: a=reg_a; b=reg_b with alu_op=01 (R) or b=imm with alu_op=10 (I) -> WB_ALU.
- ADDR: a=reg_a, b=imm, alu_op=00 -> MEM_RD (load) or MEM_WR (store).
- MEM_RD: dmem_req=1; on dmem_ready -> WB_MEM. MEM_WR: dmem_req=1, dmem_wren=1; on dmem_ready -> FETCH.
- WB_ALU / WB_MEM / WB_IMM: reg_write=1, writeback_src 00/01/10 -> FETCH.
- JUMP: reg_write=1, writeback_src=11, pc_write=1, pc_src=01 -> FETCH.
- JALR: a=reg_a, b=imm, alu_op=00, pc_src=10, pc_write=1, reg_write=1, writeback_src=11 -> FETCH (rd receives pre-update pc, i.e. old_pc+4).
- BRANCH: a=reg_a, b=reg_b, alu_op=11; pc_write=branch_taken, pc_src=01 -> FETCH.
- Timeout: 16-bit wait counter clears on entry to FETCH/MEM_RD/MEM_WR, increments each cycle ready is low; when counter == MEM_TIMEOUT with ready still low -> TRAP, cause 10.
- TRAP: all strobes 0; remains until reset; trap=1, trap_cause held.

## Timing
- Reset: state FETCH (state_dbg 0), trap 0, trap_cause 00, wait counter 0, instret 0; during the reset cycle all strobe outputs forced 0.
- Zero-wait latencies (cycles incl. FETCH): R/I-type 4, load 5, store 4, LUI/AUIPC 3, JAL/JALR 3, branch 3, FENCE/SYSTEM 2.
- Each wait cycle adds exactly one cycle; ready asserted in the request cycle completes that cycle.
- Ready sampled only in FETCH/MEM_RD/MEM_WR; ready in other states ignored.
- Ready arriving in the same cycle the counter hits MEM_TIMEOUT: ready wins, no trap.
- Reset asserted mid-instruction or in TRAP: next state FETCH, no strobes that cycle.

## Configuration
- INSTRET_COUNTER_EN defined: instret increments by 1 on every transition into FETCH from a retiring state (any non-FETCH state except TRAP), wraps 0xFFFFFFFF -> 0.
- Not defined: instret tied to 0, no counter register.

## Test plan
- ADD with imem/dmem ready always 1 -> states FETCH,DECODE,EXEC,WB_ALU; reg_write pulses once in cycle 4; instret 0->1.
- LW with dmem_ready delayed 3 cycles -> MEM_RD held 4 cycles, total 8 cycles, writeback_src=01 with reg_write in final cycle.
- BEQ with branch_taken=1 then 0 -> pc_write=1/pc_src=01 in BRANCH cycle first, pc_write=0 second; both 3 cycles.
- JALR -> single JALR cycle with pc_write=1, reg_write=1, pc_src=10, writeback_src=11.
- opcode 0000000 -> TRAP, trap=1, cause 01, no strobes for 20 cycles; reset -> FETCH, trap 0.
- MEM_TIMEOUT=4, imem_ready held 0 -> trap cause 10 on 5th cycle; repeat with ready on that cycle -> no trap.
